// File: rtl/temporizador_irrigacao_pkg.sv
// -----------------------------------------------------------------------------
// temporizador_pkg
// Shared definitions for the irrigation countdown timer:
//   estado_t        - control FSM states
//   TABELA_SEG      - seven-segment patterns {dp,g,f,e,d,c,b,a}, active-high;
//                     codes 0..9 defined, 10..15 blank
//   modulo_digito   - counting modulus of a digit position
//   limitar_digito  - clamps a loaded BCD digit to its modulus
// -----------------------------------------------------------------------------
package temporizador_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam logic [7:0] TABELA_SEG [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // In mm:ss mode the tens-of-seconds (1) and tens-of-minutes (3) digits
  // count modulo 6; every other position is decimal.
  function automatic logic [3:0] modulo_digito(input int indice, input bit modo_tempo);
    return (modo_tempo && (indice < 4) && ((indice % 2) == 1)) ? 4'd6 : 4'd10;
  endfunction

  function automatic logic [3:0] limitar_digito(input logic [3:0] valor,
                                                input logic [3:0] modulo);
    return (valor >= modulo) ? (modulo - 4'd1) : valor;
  endfunction

endpackage

// File: rtl/temporizador_irrigacao_if.sv
// -----------------------------------------------------------------------------
// temporizador_irrigacao_if
// Control and display bundle of the irrigation countdown timer.
//   master : drives tickSegundo, tickDisplay, carregar, valorCarga, iniciar,
//            pausar, habilitar; observes contagem, ativo, fim, digitos,
//            segmentos and the debug state estado.
//   slave  : the timer itself (mirror directions).
// Signalling: every control input is a single-cycle (or level) strobe sampled
// on the rising clock edge; there is no valid/ready backpressure, the timer
// accepts every strobe in the cycle it is presented.
// -----------------------------------------------------------------------------
interface temporizador_irrigacao_if #(
  parameter int DIGITOS = 4
);
  import temporizador_pkg::*;

  logic                   tickSegundo;
  logic                   tickDisplay;
  logic                   carregar;
  logic [4*DIGITOS-1:0]   valorCarga;
  logic                   iniciar;
  logic                   pausar;
  logic                   habilitar;
  logic [4*DIGITOS-1:0]   contagem;
  logic                   ativo;
  logic                   fim;
  logic [DIGITOS-1:0]     digitos;
  logic [7:0]             segmentos;
  estado_t                estado;

  modport master (
    output tickSegundo, tickDisplay, carregar, valorCarga, iniciar, pausar, habilitar,
    input  contagem, ativo, fim, digitos, segmentos, estado
  );

  modport slave (
    input  tickSegundo, tickDisplay, carregar, valorCarga, iniciar, pausar, habilitar,
    output contagem, ativo, fim, digitos, segmentos, estado
  );

endinterface

// File: rtl/temporizador_irrigacao_digito.sv
// -----------------------------------------------------------------------------
// digito_regressivo
// One BCD digit of the countdown borrow chain.
//   i_clock, i_resetN : clock, asynchronous active-low reset
//   i_load, i_valor   : load a digit (clamped to modulus-1)
//   i_dec             : decrement enable for the whole chain this cycle
//   i_borrow          : borrow-in (tied high for digit 0)
//   i_modulo          : counting modulus of this position (6 or 10)
//   o_digito          : current digit
//   o_borrow          : borrow-out = borrow-in while this digit is 0
//   o_zero            : digit equals 0
// -----------------------------------------------------------------------------
module digito_regressivo
  import temporizador_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_resetN,
  input  logic       i_load,
  input  logic [3:0] i_valor,
  input  logic       i_dec,
  input  logic       i_borrow,
  input  logic [3:0] i_modulo,
  output logic [3:0] o_digito,
  output logic       o_borrow,
  output logic       o_zero
);

  logic [3:0] r_digito;
  logic       w_zero;

  assign w_zero   = (r_digito == 4'd0);
  assign o_digito = r_digito;
  assign o_zero   = w_zero;
  // Combinational and independent of i_dec, so the chain ripples the same
  // way every cycle and the top can read "all digits zero" off the last one.
  assign o_borrow = i_borrow & w_zero;

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_digito <= 4'd0;
    end else if (i_load) begin
      r_digito <= limitar_digito(i_valor, i_modulo);
    end else if (i_dec && i_borrow) begin
      r_digito <= w_zero ? (i_modulo - 4'd1) : (r_digito - 4'd1);
    end
  end

endmodule

// File: rtl/temporizador_irrigacao.sv
// -----------------------------------------------------------------------------
// temporizador_irrigacao
// N-digit BCD countdown timer with multiplexed seven-segment display.
//   clock, resetN : single clock, asynchronous active-low reset
//   bus (slave)   : tickSegundo/tickDisplay enables, carregar+valorCarga load,
//                   iniciar/pausar control, habilitar water-level gate;
//                   contagem value, ativo, fim pulse, digitos/segmentos
//                   display drive, estado (FSM state for debug)
// Parameters: DIGITOS (2..8), MODO_TEMPO (mm:ss bases), APAGAR_ZEROS
// (leading-zero blanking), ATIVO_BAIXO (display polarity).
// -----------------------------------------------------------------------------
module temporizador_irrigacao
  import temporizador_pkg::*;
#(
  parameter int DIGITOS      = 4,
  parameter bit MODO_TEMPO   = 1'b1,
  parameter bit APAGAR_ZEROS = 1'b1,
  parameter bit ATIVO_BAIXO  = 1'b1
) (
  input  logic                      clock,
  input  logic                      resetN,
  temporizador_irrigacao_if.slave   bus
);

  localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

  estado_t              r_estado;
  estado_t              w_prox;
  logic                 r_ativo;
  logic                 r_fim;
  logic [IW-1:0]        r_indice;
  logic [DIGITOS-1:0]   r_digitos;
  logic [7:0]           r_segmentos;

  logic [3:0]           w_digito [DIGITOS];
  logic [DIGITOS-1:0]   w_zero;
  logic [DIGITOS-1:0]   w_bin;
  logic [DIGITOS-1:0]   w_bout;
  logic [4*DIGITOS-1:0] w_contagem;
  logic [DIGITOS-1:0]   w_apagado;
  logic                 w_todos_zero;
  logic                 w_altos_zero;
  logic                 w_ultimo;
  logic                 w_load;
  logic                 w_dec;
  logic [DIGITOS-1:0]   w_sel;
  logic [7:0]           w_seg;

  // ---------------------------------------------------------------------------
  // Digit chain
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DIGITOS; g++) begin : g_dig
    localparam logic [3:0] MOD = modulo_digito(g, MODO_TEMPO);

    if (g == 0) begin : g_b0
      assign w_bin[g] = 1'b1;
    end else begin : g_bn
      assign w_bin[g] = w_bout[g-1];
    end

    digito_regressivo u_digito (
      .i_clock  (clock),
      .i_resetN (resetN),
      .i_load   (w_load),
      .i_valor  (bus.valorCarga[4*g +: 4]),
      .i_dec    (w_dec),
      .i_borrow (w_bin[g]),
      .i_modulo (MOD),
      .o_digito (w_digito[g]),
      .o_borrow (w_bout[g]),
      .o_zero   (w_zero[g])
    );

    assign w_contagem[4*g +: 4] = w_digito[g];
  end

  // Zero-suffix scan from the top digit down: gives the blanking mask, the
  // "all zero" flag and "everything above digit 0 is zero".
  always_comb begin
    logic v_acc;
    v_acc        = 1'b1;
    w_apagado    = '0;
    w_altos_zero = 1'b1;
    for (int i = DIGITOS - 1; i >= 0; i--) begin
      if (i == 0) w_altos_zero = v_acc;
      v_acc        = v_acc & w_zero[i];
      w_apagado[i] = APAGAR_ZEROS && (i != 0) && v_acc;
    end
    w_todos_zero = v_acc;
  end

  // Value is exactly 1: the decrement about to happen lands on zero.
  assign w_ultimo = w_altos_zero && (w_digito[0] == 4'd1);

  // Load is accepted in every state and beats everything else.
  assign w_load = bus.carregar;

  // A borrow escaping the top digit means the value is already zero; never
  // decrement then, so the count can not wrap around.
  assign w_dec = (r_estado == CONTANDO) && bus.tickSegundo && bus.habilitar &&
                 !bus.carregar && !bus.pausar && !w_bout[DIGITOS-1];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_estado <= OCIOSO;
      r_ativo  <= 1'b0;
      r_fim    <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_ativo  <= (w_prox == CONTANDO);
      r_fim    <= (r_estado == CONTANDO) && (w_prox == FIM);
    end
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (!bus.carregar && bus.iniciar && !w_todos_zero) w_prox = CONTANDO;
      end
      CONTANDO: begin
        if (bus.carregar)          w_prox = OCIOSO;
        else if (bus.pausar)       w_prox = PAUSADO;
        else if (w_dec && w_ultimo) w_prox = FIM;
      end
      PAUSADO: begin
        if (bus.carregar)                     w_prox = OCIOSO;
        else if (!bus.pausar && bus.iniciar)  w_prox = CONTANDO;
      end
      FIM: begin
        if (bus.carregar) w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  assign w_sel = DIGITOS'(1) << r_indice;

  always_comb begin
    w_seg = w_apagado[r_indice] ? 8'h00 : TABELA_SEG[w_digito[r_indice]];
    // Colon between minutes and seconds, kept even when digit 2 is blanked.
    if (MODO_TEMPO && (int'(r_indice) == 2)) w_seg[7] = 1'b1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_indice    <= '0;
      r_digitos   <= {DIGITOS{ATIVO_BAIXO}};
      r_segmentos <= {8{ATIVO_BAIXO}};
    end else if (bus.tickDisplay) begin
      r_digitos   <= w_sel ^ {DIGITOS{ATIVO_BAIXO}};
      r_segmentos <= w_seg ^ {8{ATIVO_BAIXO}};
      if (int'(r_indice) == DIGITOS - 1) r_indice <= '0;
      else                               r_indice <= r_indice + IW'(1);
    end
  end

  assign bus.contagem  = w_contagem;
  assign bus.ativo     = r_ativo;
  assign bus.fim       = r_fim;
  assign bus.digitos   = r_digitos;
  assign bus.segmentos = r_segmentos;
  assign bus.estado    = r_estado;

endmodule
